// File: rtl/avg4_alu_sequencer_if.sv
// avg4_alu_sequencer_if: pixel-in, pixel-out and shared-ALU signals of the 2x2 averaging sequencer.
interface avg4_alu_sequencer_if #(parameter int PIX_W = 8);
  logic             in_valid, in_ready;
  logic [PIX_W-1:0] pix0, pix1, pix2, pix3;
  logic             out_valid, out_ready;
  logic [PIX_W-1:0] out_pix;
  logic [15:0]      blk_cnt, alu_a, alu_b, alu_c;
  logic [2:0]       alu_op;
  logic [3:0]       alu_shift;
  modport master (
    input  in_valid, pix0, pix1, pix2, pix3, out_ready, alu_c,
    output in_ready, out_valid, out_pix, blk_cnt, alu_a, alu_b, alu_op, alu_shift
  );
  modport slave (
    output in_valid, pix0, pix1, pix2, pix3, out_ready, alu_c,
    input  in_ready, out_valid, out_pix, blk_cnt, alu_a, alu_b, alu_op, alu_shift
  );
endinterface

// File: rtl/avg4_alu_sequencer.sv
// avg4_alu_sequencer: drives the shared ALU through ADD x3, optional INC and RSHIFT 2 to average a 2x2 pixel block.
// Define ROUND_EN to add the rounding INC step (round-half-up instead of truncation).
module avg4_alu_sequencer #(
  parameter int PIX_W = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  avg4_alu_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, ADD0, ADD1, ADD2, RND, SHR, CAP, OUT} state_t;
  localparam logic [2:0] OP_NOP = 3'b000, OP_ADD = 3'b001, OP_INC = 3'b011,
                         OP_SHR = 3'b110, OP_RST = 3'b111;
  state_t           state_q, state_d;
  logic [PIX_W-1:0] p0_q, p1_q, p2_q, p3_q, out_pix_q;
  logic [15:0]      blk_cnt_q;
  assign bus.in_ready  = rst_n && state_q == IDLE;
  assign bus.out_valid = state_q == OUT;
  assign bus.out_pix   = out_pix_q;
  assign bus.blk_cnt   = blk_cnt_q;
  always_comb begin
    state_d       = state_q;
    bus.alu_a     = '0;
    bus.alu_b     = '0;
    bus.alu_op    = OP_NOP;
    bus.alu_shift = '0;
    case (state_q)
      IDLE: begin
        bus.alu_op = OP_RST;
        state_d    = bus.in_valid ? ADD0 : IDLE;
      end
      ADD0: begin
        bus.alu_a  = 16'(p0_q);
        bus.alu_b  = 16'(p1_q);
        bus.alu_op = OP_ADD;
        state_d    = ADD1;
      end
      ADD1: begin
        bus.alu_a  = bus.alu_c;
        bus.alu_b  = 16'(p2_q);
        bus.alu_op = OP_ADD;
        state_d    = ADD2;
      end
      ADD2: begin
        bus.alu_a  = bus.alu_c;
        bus.alu_b  = 16'(p3_q);
        bus.alu_op = OP_ADD;
`ifdef ROUND_EN
        state_d    = RND;
`else
        state_d    = SHR;
`endif
      end
`ifdef ROUND_EN
      RND: begin
        bus.alu_a  = bus.alu_c;
        bus.alu_b  = 16'd1;
        bus.alu_op = OP_INC;
        state_d    = SHR;
      end
`endif
      SHR: begin
        bus.alu_a     = bus.alu_c;
        bus.alu_op    = OP_SHR;
        bus.alu_shift = 4'd2;
        state_d       = CAP;
      end
      CAP:     state_d = OUT;
      OUT:     state_d = bus.out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      p0_q      <= '0;
      p1_q      <= '0;
      p2_q      <= '0;
      p3_q      <= '0;
      out_pix_q <= '0;
      blk_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && bus.in_valid) begin
        p0_q <= bus.pix0;
        p1_q <= bus.pix1;
        p2_q <= bus.pix2;
        p3_q <= bus.pix3;
      end
      if (state_q == CAP) out_pix_q <= bus.alu_c[PIX_W-1:0];
      if (state_q == OUT && bus.out_ready) blk_cnt_q <= blk_cnt_q + 16'd1;
    end
  end
endmodule

// File: tb/tb_avg4_alu_sequencer.sv
// tb_avg4_alu_sequencer: random and directed 2x2 blocks against an arithmetic average model, with a registered ALU model.
module tb_avg4_alu_sequencer;
`ifdef ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int LAT = RND ? 6 : 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_cnt = '0;
  avg4_alu_sequencer_if #(.PIX_W(8)) bus ();
  avg4_alu_sequencer #(.PIX_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial bus.alu_c = '0;
  always @(posedge clk)
    case (bus.alu_op)
      3'b001:  bus.alu_c <= bus.alu_a + bus.alu_b;
      3'b011:  bus.alu_c <= bus.alu_a + bus.alu_b + 16'd1;
      3'b110:  bus.alu_c <= bus.alu_a >> bus.alu_shift;
      3'b111:  bus.alu_c <= '0;
      default: bus.alu_c <= bus.alu_c;
    endcase
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic run_block(input logic [7:0] a, b, c, d, input int hold);
    int sum, n, peak;
    logic [7:0] exp_pix;
    sum = int'(a) + int'(b) + int'(c) + int'(d);
    exp_pix = 8'((sum + (RND ? 2 : 0)) / 4);
    @(negedge clk);
    chk("in_ready_idle", 32'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.pix0 = a; bus.pix1 = b; bus.pix2 = c; bus.pix3 = d;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("add0_op", 32'(bus.alu_op), 1);
    chk("add0_ab", {bus.alu_a, bus.alu_b}, {8'd0, a, 8'd0, b});
    n = 0;
    peak = 0;
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
      if (int'(bus.alu_c) > peak) peak = int'(bus.alu_c);
    end
    chk("latency", 32'(n), 32'(LAT));
    chk("alu_c_peak", 32'(peak), 32'(sum + (RND ? 2 : 0)));
    chk("out_pix", 32'(bus.out_pix), 32'(exp_pix));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 1);
      chk("hold_pix", 32'(bus.out_pix), 32'(exp_pix));
      chk("hold_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    exp_cnt = exp_cnt + 16'd1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("blk_cnt", 32'(bus.blk_cnt), 32'(exp_cnt));
    chk("out_valid_drop", 32'(bus.out_valid), 0);
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.pix0 = '0; bus.pix1 = '0; bus.pix2 = '0; bus.pix3 = '0;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_op", 32'(bus.alu_op), 7);
    chk("rst_ab_shift", {bus.alu_a, bus.alu_b} | 32'(bus.alu_shift), 0);
    chk("rst_out", {bus.out_valid, bus.out_pix, bus.blk_cnt}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.pix0 = 8'd5; bus.pix1 = 8'd6; bus.pix2 = 8'd7; bus.pix3 = 8'd8;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("add1_op", 32'(bus.alu_op), 1);
    chk("add1_b", 32'(bus.alu_b), 7);
    rst_n = 1'b0;
    #1;
    chk("midrst_op", 32'(bus.alu_op), 7);
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("midrst_no_out", {bus.out_valid, bus.blk_cnt}, 0);
    end
    run_block(8'd10, 8'd20, 8'd30, 8'd40, 0);
    run_block(8'd1, 8'd1, 8'd1, 8'd2, 0);
    run_block(8'd1, 8'd2, 8'd2, 8'd2, 0);
    run_block(8'd255, 8'd255, 8'd255, 8'd255, 0);
    run_block(8'd0, 8'd0, 8'd0, 8'd0, 1);
    run_block(8'd3, 8'd200, 8'd77, 8'd129, 10);
    for (int i = 0; i < 10; i++)
      run_block(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)));
    force dut.blk_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.blk_cnt_q;
    @(negedge clk);
    chk("cnt_preload", 32'(bus.blk_cnt), 32'hFFFF);
    exp_cnt = 16'hFFFF;
    run_block(8'd9, 8'd9, 8'd9, 8'd9, 0);
    chk("cnt_wrap", 32'(bus.blk_cnt), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
